swo_uart_rx: RTL and testbench
==============================

Name: swo_uart_rx

Overview:
- SWO/UART asynchronous receiver for the trace capture path.
- Deserialises the target's SWO pin into bytes for the trace capture/trigger logic.
- Consumes the UART configuration produced by the trace register block: enable, bitrate divider, stop bits, data bits and the uart_reset pulse.
- Returns its 3-bit state for register readback as uart_state.

Parameters:
pDIV_WIDTH, 16, width of the bitrate divider.

Ports:
trace_clk  input  1  receiver clock; same domain as the configuration inputs.
reset_n  input  1  asynchronous active-low reset.
I_swo  input  1  raw SWO pin; asynchronous; idles high.
I_swo_enable  input  1  receiver enable.
I_bitrate_div  input  pDIV_WIDTH  bit period = I_bitrate_div+1 trace_clk cycles.
I_stop_bits  input  2  stop-bit count.
I_data_bits  input  4  data-bit count.
I_uart_reset  input  1  single-cycle soft reset.
O_data  output  8  received byte, right-justified, LSB-first on the wire.
O_data_valid  output  1  one-cycle strobe; O_data is valid while it is high.
O_framing_error  output  1  sticky framing-error flag.
O_state  output  3  FSM state, used for uart_state readback.

Behaviour:
- Reset values (on reset_n low): O_data=0, O_data_valid=0, O_framing_error=0, O_state=IDLE. Sync flops are forced to 1.
- Input synchronisation: I_swo passes through a 2-flop synchroniser (swo_s). A registered copy swo_d is kept. Falling edge = swo_s==0 && swo_d==1.
- Configuration latching: div, effective data-bit count and effective stop-bit count are latched on the start-edge cycle. Changes mid-frame affect only the next frame.
- Effective data bits: I_data_bits 1..8 used as-is; 0 or >8 -> 8.
- Effective stop bits: 0 or 1 -> 1; 2 or 3 -> 2.
- Baud counter: down-counter. A sample is taken on the cycle the counter equals 0, and the counter reloads in that same cycle.
- State encoding: IDLE=0, START=1, DATA=2, STOP=3, WAIT_HIGH=4.
- IDLE:
  - On a falling edge with I_swo_enable=1: go to START, counter <= div>>1.
- START (counter==0):
  - swo_s==1 (false start): go to IDLE, no output.
  - Otherwise: go to DATA, counter <= div, bit index = 0.
- DATA (counter==0):
  - Shift swo_s into bit[index] and counter <= div.
  - After the last data bit: go to STOP, counter <= div.
- STOP (counter==0):
  - Sample swo_s for each stop bit.
  - Any stop sample 0: O_framing_error <= 1, byte discarded, go to WAIT_HIGH.
  - After all stop bits sample 1: O_data <= assembled byte with unused upper bits 0, O_data_valid=1 for exactly one cycle (the cycle after the final stop sample), go to IDLE.
- WAIT_HIGH:
  - Go to IDLE on the first cycle swo_s==1. A falling edge is not recognised until then, so a break condition produces no bytes.
- Timing, with the falling edge detected at cycle t and D=div:
  - Start sample at t+(D>>1)+1.
  - Bit k sample at t+(D>>1)+1+(k+1)(D+1).
  - O_data_valid one cycle after the last stop sample.
  - Pin-to-detect latency is 2 cycles.
- Back-to-back frames: returning to IDLE in the valid cycle allows a start edge in the very next cycle. The inter-frame gap needed is zero beyond the stop bits.
- D=0: period is 1 cycle and half-period is 0; sampling occurs on the cycle after each load. This must work.
- I_swo_enable=0 in any state:
  - Next cycle the FSM is IDLE and the partial byte is discarded.
  - No O_data_valid; O_data is held.
  - O_framing_error is unchanged.
- I_uart_reset=1:
  - Next cycle the FSM is IDLE, counters are cleared and O_framing_error is cleared.
  - O_data is held.
  - Takes priority over every FSM transition and over framing-error setting in the same cycle.
- O_data holds its value until the next valid byte.

Test Plan:
- div=7, data_bits=8, stop_bits=1, send 0xA5 -> exactly one O_data_valid at detect+77 cycles; O_data=0xA5; O_framing_error=0.
- div=7, data_bits=5, stop_bits=2, send 0x1F then 0x0A back-to-back with no gap -> two strobes; O_data=0x1F then 0x0A; O_state passes 1,2,3,0.
- 2-cycle low glitch on an idle line, div=15 -> START then IDLE; no strobe.
- Stop bit driven low on byte 0x3C, then a 40-cycle break -> O_framing_error=1, no strobe, O_state=4 until the line rises; next good byte 0x55 is received with the error still 1; an I_uart_reset pulse clears it to 0.
- I_swo_enable dropped mid-DATA, then re-enabled and 0x81 sent -> no strobe for the aborted frame; O_data=0x81 afterwards.
- div=0, send 0xFF and 0x00 -> both received correctly. Repeat with reset_n asserted mid-frame -> all outputs at reset values immediately and asynchronously.

Source files
------------

// File: rtl/swo_uart_rx.sv
// SWO/UART asynchronous receiver: synchronises the SWO pin, finds the start edge,
// samples each bit mid-period with a reloading down-counter and emits bytes with a valid strobe.
module swo_uart_rx #(
    parameter int pDIV_WIDTH = 16
) (
    input  logic                  trace_clk,
    input  logic                  reset_n,
    input  logic                  I_swo,
    input  logic                  I_swo_enable,
    input  logic [pDIV_WIDTH-1:0] I_bitrate_div,
    input  logic [1:0]            I_stop_bits,
    input  logic [3:0]            I_data_bits,
    input  logic                  I_uart_reset,
    output logic [7:0]            O_data,
    output logic                  O_data_valid,
    output logic                  O_framing_error,
    output logic [2:0]            O_state
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } state_t;

    localparam logic [pDIV_WIDTH-1:0] CNT_ZERO = {pDIV_WIDTH{1'b0}};
    localparam logic [pDIV_WIDTH-1:0] CNT_ONE  = {{(pDIV_WIDTH-1){1'b0}}, 1'b1};

    // Data-bit count minus one; out-of-range counts fall back to a full byte.
    function automatic logic [2:0] eff_bits_m1(input logic [3:0] n);
        if ((n == 4'd0) || (n > 4'd8)) begin
            return 3'd7;
        end else begin
            return 3'(n - 4'd1);
        end
    endfunction

    logic                  sync1_q, swo_s_q, swo_d_q;
    state_t                state_q, state_d;
    logic [pDIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [pDIV_WIDTH-1:0] div_q, div_d;
    logic [2:0]            nbits_m1_q, nbits_m1_d;
    logic                  stop2_q, stop2_d;
    logic                  stop_idx_q, stop_idx_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic [7:0]            shreg_q, shreg_d;
    logic [7:0]            data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  ferr_q, ferr_d;
    logic                  fall_s;
    logic                  cnt_zero_s;

    assign fall_s     = (swo_s_q == 1'b0) && (swo_d_q == 1'b1);
    assign cnt_zero_s = (cnt_q == CNT_ZERO);

    // Next-state logic: soft reset beats disable, which beats every FSM transition.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        nbits_m1_d = nbits_m1_q;
        stop2_d    = stop2_q;
        stop_idx_d = stop_idx_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ferr_d     = ferr_q;

        if (I_uart_reset) begin
            state_d    = ST_IDLE;
            cnt_d      = CNT_ZERO;
            bit_idx_d  = 3'd0;
            stop_idx_d = 1'b0;
            ferr_d     = 1'b0;
        end else if (!I_swo_enable) begin
            state_d    = ST_IDLE;
            cnt_d      = CNT_ZERO;
            bit_idx_d  = 3'd0;
            stop_idx_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fall_s) begin
                        // Frame configuration is frozen here for the whole frame.
                        state_d    = ST_START;
                        div_d      = I_bitrate_div;
                        cnt_d      = I_bitrate_div >> 1;
                        nbits_m1_d = eff_bits_m1(I_data_bits);
                        stop2_d    = (I_stop_bits >= 2'd2);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (!cnt_zero_s) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else if (swo_s_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_DATA;
                        cnt_d     = div_q;
                        bit_idx_d = 3'd0;
                        shreg_d   = 8'h00;
                    end
                end
                ST_DATA: begin
                    if (!cnt_zero_s) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else begin
                        shreg_d[bit_idx_q] = swo_s_q;
                        cnt_d              = div_q;
                        if (bit_idx_q == nbits_m1_q) begin
                            state_d    = ST_STOP;
                            stop_idx_d = 1'b0;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (!cnt_zero_s) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else begin
                        cnt_d = div_q;
                        if (!swo_s_q) begin
                            ferr_d  = 1'b1;
                            state_d = ST_WAIT_HIGH;
                        end else if (stop_idx_q == stop2_q) begin
                            data_d  = shreg_q;
                            valid_d = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            stop_idx_d = 1'b1;
                        end
                    end
                end
                ST_WAIT_HIGH: begin
                    // A held-low line (break) must rise before a new start edge counts.
                    if (swo_s_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_HIGH;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Pin synchroniser and edge-detect history; idles high.
    always_ff @(posedge trace_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            swo_s_q <= 1'b1;
            swo_d_q <= 1'b1;
        end else begin
            sync1_q <= I_swo;
            swo_s_q <= sync1_q;
            swo_d_q <= swo_s_q;
        end
    end

    // Receiver state, counters and registered outputs.
    always_ff @(posedge trace_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= CNT_ZERO;
            div_q      <= CNT_ZERO;
            nbits_m1_q <= 3'd7;
            stop2_q    <= 1'b0;
            stop_idx_q <= 1'b0;
            bit_idx_q  <= 3'd0;
            shreg_q    <= 8'h00;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            nbits_m1_q <= nbits_m1_d;
            stop2_q    <= stop2_d;
            stop_idx_q <= stop_idx_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
        end
    end

    assign O_data          = data_q;
    assign O_data_valid    = valid_q;
    assign O_framing_error = ferr_q;
    assign O_state         = state_q;

endmodule

// File: tb/tb_swo_uart_rx.sv
// Scoreboard bench for swo_uart_rx: directed frames push expected {ferr,data} entries,
// a negedge monitor pops and compares on every O_data_valid strobe.
module tb_swo_uart_rx;

    logic        trace_clk;
    logic        reset_n;
    logic        I_swo;
    logic        I_swo_enable;
    logic [15:0] I_bitrate_div;
    logic [1:0]  I_stop_bits;
    logic [3:0]  I_data_bits;
    logic        I_uart_reset;
    logic [7:0]  O_data;
    logic        O_data_valid;
    logic        O_framing_error;
    logic [2:0]  O_state;

    swo_uart_rx #(.pDIV_WIDTH(16)) dut (
        .trace_clk       (trace_clk),
        .reset_n         (reset_n),
        .I_swo           (I_swo),
        .I_swo_enable    (I_swo_enable),
        .I_bitrate_div   (I_bitrate_div),
        .I_stop_bits     (I_stop_bits),
        .I_data_bits     (I_data_bits),
        .I_uart_reset    (I_uart_reset),
        .O_data          (O_data),
        .O_data_valid    (O_data_valid),
        .O_framing_error (O_framing_error),
        .O_state         (O_state)
    );

    initial trace_clk = 1'b0;
    always #5 trace_clk = ~trace_clk;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          valid_count = 0;
    int          valid_cyc = 0;
    int          start_cyc = 0;
    logic [8:0]  exp_q[$];
    logic [2:0]  trace_q[$];
    logic [2:0]  prev_state = 3'd0;

    always @(posedge trace_clk) cyc <= cyc + 1;

    // Monitor: state trace, start timestamp and scoreboard compare on each strobe.
    always @(negedge trace_clk) begin
        if (reset_n) begin
            if (O_state != prev_state) begin
                trace_q.push_back(O_state);
                if ((O_state == 3'd1) && (prev_state == 3'd0)) start_cyc = cyc;
            end
            prev_state = O_state;
            if (O_data_valid) begin
                valid_count++;
                valid_cyc = cyc;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_strobe: got data=%02h, required no strobe", O_data);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    if ({O_framing_error, O_data} !== e) begin
                        fails++;
                        $display("FAIL strobe_data: got ferr=%0b data=%02h, required ferr=%0b data=%02h",
                                 O_framing_error, O_data, e[8], e[7:0]);
                    end
                end
            end
        end else begin
            prev_state = 3'd0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] trace_word();
        logic [31:0] v;
        v = 32'h0;
        foreach (trace_q[i]) v = (v << 4) | {29'd0, trace_q[i]};
        return v;
    endfunction

    task automatic drive(input logic v, input int n);
        I_swo = v;
        repeat (n) @(negedge trace_clk);
    endtask

    // At D=0 the start sample lands one cycle after detect, so the start bit is held two cycles.
    task automatic send_frame(input logic [7:0] b, input int nb, input int ns, input int d,
                              input logic stop_val);
        drive(1'b0, (d == 0) ? 2 : d + 1);
        for (int i = 0; i < nb; i++) drive(b[i], d + 1);
        drive(stop_val, ns * (d + 1));
    endtask

    initial begin
        reset_n       = 1'b0;
        I_swo         = 1'b1;
        I_swo_enable  = 1'b1;
        I_bitrate_div = 16'd7;
        I_stop_bits   = 2'd1;
        I_data_bits   = 4'd8;
        I_uart_reset  = 1'b0;
        repeat (3) @(negedge trace_clk);
        check("reset_outputs", {19'd0, O_data, O_data_valid, O_framing_error, O_state}, 32'h0);
        reset_n = 1'b1;
        repeat (4) @(negedge trace_clk);

        // 0xA5, 8N1, div=7: strobe 77 cycles after detect
        trace_q.delete();
        exp_q.push_back({1'b0, 8'hA5});
        send_frame(8'hA5, 8, 1, 7, 1'b1);
        drive(1'b1, 6);
        check("a5_latency", valid_cyc - start_cyc, 32'd76);
        check("a5_strobe_count", valid_count, 32'd1);
        check("a5_state_trace", trace_word(), 32'h1230);

        // 5 data bits, 2 stop bits, back-to-back
        I_data_bits = 4'd5;
        I_stop_bits = 2'd2;
        trace_q.delete();
        exp_q.push_back({1'b0, 8'h1F});
        exp_q.push_back({1'b0, 8'h0A});
        send_frame(8'h1F, 5, 2, 7, 1'b1);
        send_frame(8'h0A, 5, 2, 7, 1'b1);
        drive(1'b1, 6);
        check("b2b_strobe_count", valid_count, 32'd3);
        check("b2b_state_trace", trace_word(), 32'h12301230);

        // 2-cycle glitch at div=15 is a false start
        I_bitrate_div = 16'd15;
        I_data_bits   = 4'd8;
        I_stop_bits   = 2'd1;
        trace_q.delete();
        drive(1'b0, 2);
        drive(1'b1, 30);
        check("glitch_trace", trace_word(), 32'h10);
        check("glitch_no_strobe", valid_count, 32'd3);

        // Framing error + break, recovery, soft reset clears the flag
        I_bitrate_div = 16'd7;
        send_frame(8'h3C, 8, 1, 7, 1'b0);
        drive(1'b0, 40);
        check("break_state", O_state, 32'd4);
        check("break_ferr", O_framing_error, 32'd1);
        check("break_no_strobe", valid_count, 32'd3);
        drive(1'b1, 6);
        check("break_release_state", O_state, 32'd0);
        exp_q.push_back({1'b1, 8'h55});
        send_frame(8'h55, 8, 1, 7, 1'b1);
        drive(1'b1, 4);
        I_uart_reset = 1'b1;
        @(negedge trace_clk);
        I_uart_reset = 1'b0;
        check("soft_reset_ferr", O_framing_error, 32'd0);
        check("soft_reset_data_held", O_data, 32'h55);

        // Disable mid-DATA aborts the frame
        drive(1'b0, 8);
        drive(1'b1, 8);
        drive(1'b0, 8);
        drive(1'b0, 4);
        check("abort_in_data", O_state, 32'd2);
        I_swo_enable = 1'b0;
        I_swo        = 1'b1;
        @(negedge trace_clk);
        check("abort_state_idle", O_state, 32'd0);
        repeat (20) @(negedge trace_clk);
        I_swo_enable = 1'b1;
        repeat (4) @(negedge trace_clk);
        check("abort_no_strobe", valid_count, 32'd4);
        exp_q.push_back({1'b0, 8'h81});
        send_frame(8'h81, 8, 1, 7, 1'b1);
        drive(1'b1, 4);
        check("after_abort_data", O_data, 32'h81);

        // div=0, data_bits=0 -> 8, stop_bits=0 -> 1
        I_bitrate_div = 16'd0;
        I_data_bits   = 4'd0;
        I_stop_bits   = 2'd0;
        exp_q.push_back({1'b0, 8'hFF});
        exp_q.push_back({1'b0, 8'h00});
        send_frame(8'hFF, 8, 1, 0, 1'b1);
        send_frame(8'h00, 8, 1, 0, 1'b1);
        drive(1'b1, 4);
        exp_q.push_back({1'b0, 8'hFF});
        send_frame(8'hFF, 8, 1, 0, 1'b1);
        drive(1'b1, 4);
        check("div0_count", valid_count, 32'd8);
        check("div0_data", O_data, 32'hFF);

        // Asynchronous reset mid-frame
        I_bitrate_div = 16'd7;
        fork
            send_frame(8'h5A, 8, 1, 7, 1'b1);
        join_none
        repeat (30) @(negedge trace_clk);
        check("pre_reset_state", O_state, 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", {19'd0, O_data, O_data_valid, O_framing_error, O_state}, 32'h0);
        repeat (100) @(negedge trace_clk);
        reset_n = 1'b1;
        repeat (10) @(negedge trace_clk);
        check("final_queue_empty", exp_q.size(), 32'd0);
        check("final_strobe_count", valid_count, 32'd8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
